// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types.
// Branch history table state, sizing and PC-to-index mapping.
package rv32i_types;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  localparam int BHT_IDX_BITS = 6;

  function automatic logic [31:0] bht_idx(
    input logic [31:0] pc,
    input int          bits
  );
    return (pc >> 2) & ((32'd1 << bits) - 32'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating direction counter.
// Resets to weakly-not-taken; moves one step per enabled cycle.
module sat_counter2
  import rv32i_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       inc,
  output logic [1:0] q
);

  bht_state_t st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= WNT;
    end else if (en) begin
      if (inc) begin
        if (st != ST) st <= bht_state_t'(st + 2'd1);
      end else begin
        if (st != SNT) st <= bht_state_t'(st - 2'd1);
      end
    end
  end

  assign q = st;

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side BHT/BTB branch predictor.
// Predicts for if_pc, checks resolved EX branches and trains.
module branch_predictor
  import rv32i_types::*;
#(
  parameter int IDX_BITS = BHT_IDX_BITS,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [31:0]      ex_pc,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  input  logic [31:0]      ex_target,
  input  logic             br_en,
  input  logic             stall,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int N = 1 << IDX_BITS;

  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic [1:0]          ctr [N];
  logic [N-1:0]        btb_valid;
  logic [31:0]         btb_target [N];
  logic                res;
  logic                mis;
  logic                upd;

  assign if_idx = IDX_BITS'(bht_idx(if_pc, IDX_BITS));
  assign ex_idx = IDX_BITS'(bht_idx(ex_pc, IDX_BITS));

  assign pred_taken  = btb_valid[if_idx] & ctr[if_idx][1];
  assign pred_target = btb_target[if_idx];

  assign res = ex_valid & ex_is_branch;
  assign mis = res & ((br_en != ex_pred_taken) |
               (br_en & ex_pred_taken & (ex_pred_target != ex_target)));
  assign upd = res & ~stall & ~rst;

  assign redirect    = mis & ~rst;
  assign redirect_pc = !mis  ? 32'd0 :
                       br_en ? ex_target : ex_pc + 32'd4;

  for (genvar i = 0; i < N; i++) begin : g_ctr
    sat_counter2 u_ctr (
      .clk (clk),
      .rst (rst),
      .en  (upd && (ex_idx == IDX_BITS'(i))),
      .inc (br_en),
      .q   (ctr[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (upd && br_en) begin
      btb_valid[ex_idx] <= 1'b1;
    end
  end

  // Targets are qualified by btb_valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (upd && br_en) begin
      btb_target[ex_idx] <= ex_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (upd) begin
      if (branch_count != '1)
        branch_count <= branch_count + 1'b1;
      if (mis && mispredict_count != '1)
        mispredict_count <= mispredict_count + 1'b1;
    end
  end

endmodule
